// File: rtl/dcache_wb_pkg.sv
// Shared cache definitions for the dcache writeback path.
// Holds the line/tag/index widths, the word-slot positions inside a line, the generic
// ENABLE/DISABLE strobe levels, the writeback FSM state encoding and a line-packing helper.
package dcache_wb_pkg;

   localparam int unsigned LineWidth  = 128;
   localparam int unsigned TagWidth   = 20;
   localparam int unsigned IndexWidth = 8;
   localparam int unsigned AddrWidth  = TagWidth + IndexWidth;

   // Word slots inside a line: word0 occupies [31:0], word3 occupies [127:96].
   localparam int unsigned WORD0 = 0;
   localparam int unsigned WORD1 = 1;
   localparam int unsigned WORD2 = 2;
   localparam int unsigned WORD3 = 3;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRead    = 3'd1,
      StCapture = 3'd2,
      StSend    = 3'd3,
      StDone    = 3'd4
   } wb_state_e;

   // Build a line from four 32-bit words in slot order.
   function automatic logic [LineWidth-1:0] pack_line(input logic [31:0] w0,
                                                      input logic [31:0] w1,
                                                      input logic [31:0] w2,
                                                      input logic [31:0] w3);
      logic [LineWidth-1:0] line;
      line = '0;
      line[WORD0*32 +: 32] = w0;
      line[WORD1*32 +: 32] = w1;
      line[WORD2*32 +: 32] = w2;
      line[WORD3*32 +: 32] = w3;
      return line;
   endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Bus bundle for the dcache writeback engine.
// Carries the victim request (wb_start/wb_way/wb_index/wb_tag), the data-RAM read port
// (index, block0_re/block1_re, data0_rd/data1_rd), the L2 line-write handshake
// (l2_wr_req/l2_wr_addr/l2_wr_data/l2_wr_ack) and status (wb_busy, wb_done).
// master: the writeback engine. slave: the surrounding cache / L2 side.
interface dcache_wb_if;
   import dcache_wb_pkg::*;

   logic                  wb_start;
   logic                  wb_way;
   logic [IndexWidth-1:0] wb_index;
   logic [TagWidth-1:0]   wb_tag;
   logic [IndexWidth-1:0] index;
   logic                  block0_re;
   logic                  block1_re;
   logic [LineWidth-1:0]  data0_rd;
   logic [LineWidth-1:0]  data1_rd;
   logic                  l2_wr_req;
   logic [AddrWidth-1:0]  l2_wr_addr;
   logic [LineWidth-1:0]  l2_wr_data;
   logic                  l2_wr_ack;
   logic                  wb_busy;
   logic                  wb_done;

   modport master (
      input  wb_start, wb_way, wb_index, wb_tag, data0_rd, data1_rd, l2_wr_ack,
      output index, block0_re, block1_re, l2_wr_req, l2_wr_addr, l2_wr_data, wb_busy, wb_done
   );

   modport slave (
      output wb_start, wb_way, wb_index, wb_tag, data0_rd, data1_rd, l2_wr_ack,
      input  index, block0_re, block1_re, l2_wr_req, l2_wr_addr, l2_wr_data, wb_busy, wb_done
   );

endinterface

// File: rtl/dcache_wb.sv
// Dirty-victim writeback engine for a 2-way data cache.
// On wb_start (sampled only when idle) it latches way/index/tag, reads the victim line from
// the selected data RAM, captures it into a line buffer, and holds an L2 line write until
// l2_wr_ack, then pulses wb_done for one cycle.
// Ports: clk - system clock; reset - asynchronous active-low reset;
//        bus - dcache_wb_if master modport (request, RAM read port, L2 write, status).
module dcache_wb
   import dcache_wb_pkg::*;
(
   input logic         clk,
   input logic         reset,
   dcache_wb_if.master bus
);

   wb_state_e             state_q, state_d;
   logic                  way_q, way_d;
   logic [IndexWidth-1:0] index_q, index_d;
   logic [TagWidth-1:0]   tag_q, tag_d;
   logic [LineWidth-1:0]  line_q, line_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         way_q   <= 1'b0;
         index_q <= '0;
         tag_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         way_q   <= way_d;
         index_q <= index_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      way_d         = way_q;
      index_d       = index_q;
      tag_d         = tag_q;
      line_d        = line_q;
      bus.index     = '0;
      bus.block0_re = DISABLE;
      bus.block1_re = DISABLE;
      bus.l2_wr_req = DISABLE;
      bus.wb_busy   = DISABLE;
      bus.wb_done   = DISABLE;

      unique case (state_q)
         StIdle: begin
            if (bus.wb_start) begin
               way_d   = bus.wb_way;
               index_d = bus.wb_index;
               tag_d   = bus.wb_tag;
               state_d = StRead;
            end
         end
         StRead: begin
            bus.index     = index_q;
            bus.block0_re = ~way_q;
            bus.block1_re = way_q;
            bus.wb_busy   = ENABLE;
            state_d       = StCapture;
         end
         StCapture: begin
            // RAM data is valid one cycle after the read enable, i.e. now.
            line_d      = way_q ? bus.data1_rd : bus.data0_rd;
            bus.wb_busy = ENABLE;
            state_d     = StSend;
         end
         StSend: begin
            bus.l2_wr_req = ENABLE;
            bus.wb_busy   = ENABLE;
            if (bus.l2_wr_ack) begin
               state_d = StDone;
            end
         end
         StDone: begin
            bus.wb_done = ENABLE;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Address and data come straight from the latched fields, so they cannot move while
   // the request is held; reset clears them along with the state.
   assign bus.l2_wr_addr = {tag_q, index_q};
   assign bus.l2_wr_data = line_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: directed writebacks with hand-computed expected L2 writes queued
// into a scoreboard that a negedge monitor drains on each accepted L2 write.
module tb_dcache_wb;
   import dcache_wb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dcache_wb_if bus ();

   dcache_wb dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Data RAM model: registered read, one cycle of latency. toggle0 scribbles on way 0.
   logic [127:0] line0 = '0;
   logic [127:0] line1 = '0;
   logic [127:0] data0_q = '0;
   logic [127:0] data1_q = '0;
   logic         toggle0 = 1'b0;

   always @(posedge clk) begin
      if (toggle0) data0_q <= ~data0_q;
      else if (bus.block0_re) data0_q <= line0;
      if (bus.block1_re) data1_q <= line1;
   end

   assign bus.data0_rd = data0_q;
   assign bus.data1_rd = data1_q;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [27:0]  addr;
      logic [127:0] data;
   } exp_t;
   exp_t exp_q[$];

   // Monitor: addr/data must stay put across a held request; on ack, compare to scoreboard.
   logic         in_send = 1'b0;
   logic [27:0]  held_addr;
   logic [127:0] held_data;
   int           done_count = 0;

   always @(negedge clk) begin
      exp_t e;
      if (bus.wb_done === 1'b1) done_count++;
      if (bus.l2_wr_req === 1'b1) begin
         if (!in_send) begin
            held_addr = bus.l2_wr_addr;
            held_data = bus.l2_wr_data;
            in_send   = 1'b1;
         end else begin
            check("send_addr_stable", bus.l2_wr_addr, held_addr);
            check("send_data_stable", bus.l2_wr_data, held_data);
         end
         if (bus.l2_wr_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: got addr %0h expected none", bus.l2_wr_addr);
            end else begin
               e = exp_q.pop_front();
               check("l2_wr_addr", bus.l2_wr_addr, e.addr);
               check("l2_wr_data", bus.l2_wr_data, e.data);
            end
            in_send = 1'b0;
         end
      end else begin
         in_send = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic way, input logic [7:0] idx, input logic [19:0] tag,
                        input logic [127:0] line);
      bus.wb_start = 1'b1;
      bus.wb_way   = way;
      bus.wb_index = idx;
      bus.wb_tag   = tag;
      if (way) line1 = line;
      else line0 = line;
      exp_q.push_back('{addr: {tag, idx}, data: line});
   endtask

   initial begin
      reset        = 1'b0;
      bus.wb_start = 1'b0;
      bus.wb_way   = 1'b0;
      bus.wb_index = '0;
      bus.wb_tag   = '0;
      bus.l2_wr_ack = 1'b0;

      // Reset state
      #2;
      check("rst_req", bus.l2_wr_req, 0);
      check("rst_busy", bus.wb_busy, 0);
      check("rst_done", bus.wb_done, 0);
      check("rst_re", {bus.block1_re, bus.block0_re}, 0);
      check("rst_index", bus.index, 0);
      check("rst_addr", bus.l2_wr_addr, 0);
      check("rst_data", bus.l2_wr_data, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Way 0, ack held high: minimum latency
      tick();
      start(1'b0, 8'h3C, 20'hABCDE, pack_line(32'h1, 32'h2, 32'h3, 32'h4));
      check("t1_line_const", line0, 128'h00000004_00000003_00000002_00000001);
      bus.l2_wr_ack = 1'b1;
      @(negedge clk);
      check("t1_n_busy", bus.wb_busy, 0);
      tick();
      bus.wb_start = 1'b0;
      @(negedge clk);
      check("t1_n1_re0", bus.block0_re, 1);
      check("t1_n1_re1", bus.block1_re, 0);
      check("t1_n1_index", bus.index, 8'h3C);
      check("t1_n1_busy", bus.wb_busy, 1);
      tick();
      @(negedge clk);
      check("t1_n2_re0", bus.block0_re, 0);
      check("t1_n2_req", bus.l2_wr_req, 0);
      tick();
      @(negedge clk);
      check("t1_n3_req", bus.l2_wr_req, 1);
      tick();
      @(negedge clk);
      check("t1_n4_done", bus.wb_done, 1);
      check("t1_n4_busy", bus.wb_busy, 0);
      check("t1_n4_req", bus.l2_wr_req, 0);
      tick();
      bus.l2_wr_ack = 1'b0;
      @(negedge clk);
      check("t1_n5_done", bus.wb_done, 0);

      // Way 1, ack delayed 5 cycles: request held 6 cycles
      tick();
      start(1'b1, 8'hFF, 20'h12345, pack_line(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
                                               32'hD3D3D3D3));
      tick();
      bus.wb_start = 1'b0;
      @(negedge clk);
      check("t2_re1", bus.block1_re, 1);
      check("t2_re0", bus.block0_re, 0);
      check("t2_index", bus.index, 8'hFF);
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 5) bus.l2_wr_ack = 1'b1;
         @(negedge clk);
         check("t2_req_held", bus.l2_wr_req, 1);
         check("t2_no_early_done", bus.wb_done, 0);
      end
      tick();
      bus.l2_wr_ack = 1'b0;
      @(negedge clk);
      check("t2_done", bus.wb_done, 1);
      check("t2_req_off", bus.l2_wr_req, 0);
      tick();
      @(negedge clk);
      check("t2_done_once", bus.wb_done, 0);

      // Second start during SEND ignored; way-0 RAM output toggles during SEND
      tick();
      start(1'b0, 8'h11, 20'h0F0F0, pack_line(32'h11111111, 32'h22222222, 32'h33333333,
                                               32'h44444444));
      tick();
      bus.wb_start = 1'b0;
      tick();
      tick();
      toggle0      = 1'b1;
      bus.wb_start = 1'b1;
      bus.wb_way   = 1'b1;
      bus.wb_index = 8'h22;
      bus.wb_tag   = 20'h55555;
      @(negedge clk);
      check("t3_req", bus.l2_wr_req, 1);
      tick();
      bus.wb_start = 1'b0;
      @(negedge clk);
      check("t3_busy", bus.wb_busy, 1);
      tick();
      bus.l2_wr_ack = 1'b1;
      @(negedge clk);
      check("t3_req_ack", bus.l2_wr_req, 1);
      tick();
      bus.l2_wr_ack = 1'b0;
      toggle0 = 1'b0;
      @(negedge clk);
      check("t3_done", bus.wb_done, 1);
      tick();
      @(negedge clk);
      check("t3_busy_low", bus.wb_busy, 0);
      check("t3_done_once", bus.wb_done, 0);
      tick();
      @(negedge clk);
      check("t3_no_restart", bus.wb_busy, 0);

      // Reset asserted in SEND aborts without a clock edge
      tick();
      start(1'b1, 8'h44, 20'h77777, pack_line(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003,
                                               32'hDEAD0004));
      tick();
      bus.wb_start = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("t4_req_before", bus.l2_wr_req, 1);
      #1;
      reset = 1'b0;
      #1;
      check("t4_req_async", bus.l2_wr_req, 0);
      check("t4_busy_async", bus.wb_busy, 0);
      check("t4_addr_clr", bus.l2_wr_addr, 0);
      check("t4_data_clr", bus.l2_wr_data, 0);
      void'(exp_q.pop_back());
      tick();
      tick();
      @(negedge clk);
      check("t4_no_done", bus.wb_done, 0);
      reset = 1'b1;

      // Spurious ack in IDLE and READ, then a normal writeback after reset
      bus.l2_wr_ack = 1'b1;
      tick();
      @(negedge clk);
      check("t5_idle_busy", bus.wb_busy, 0);
      check("t5_idle_done", bus.wb_done, 0);
      tick();
      start(1'b0, 8'h5A, 20'h0BEEF, pack_line(32'hCAFE0000, 32'hCAFE1111, 32'hCAFE2222,
                                               32'hCAFE3333));
      @(negedge clk);
      tick();
      bus.wb_start = 1'b0;
      @(negedge clk);
      check("t5_read_re0", bus.block0_re, 1);
      check("t5_read_done", bus.wb_done, 0);
      tick();
      @(negedge clk);
      check("t5_capture_busy", bus.wb_busy, 1);
      check("t5_capture_req", bus.l2_wr_req, 0);
      tick();
      @(negedge clk);
      check("t5_send_req", bus.l2_wr_req, 1);
      tick();
      @(negedge clk);
      check("t5_done", bus.wb_done, 1);
      tick();
      bus.l2_wr_ack = 1'b0;
      @(negedge clk);
      check("t5_done_off", bus.wb_done, 0);

      tick();
      check("done_count", done_count, 4);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 Clocking SHALL be: one clock, clk; reset is asynchronous and active-low, port reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 wb_start  in  1  one-cycle request to write back a dirty victim line; sampled only in IDLE.
REQ-005 wb_way  in  1  victim way (0 = block0, 1 = block1).
REQ-006 wb_index  in  8  victim set index.
REQ-007 wb_tag  in  20  victim tag.
REQ-008 index  out  8  data-RAM address.
REQ-009 block0_re  out  1  read enable, way-0 data RAM.
REQ-010 block1_re  out  1  read enable, way-1 data RAM.
REQ-011 data0_rd  in  128  way-0 read data; valid one cycle after the read enable.
REQ-012 data1_rd  in  128  way-1 read data; valid one cycle after the read enable.
REQ-013 l2_wr_req  out  1  L2 line-write request.
REQ-014 l2_wr_addr  out  28  line address {tag, index}.
REQ-015 l2_wr_data  out  128  line data; word0 in [31:0], word3 in [127:96].
REQ-016 l2_wr_ack  in  1  L2 accepted the line.
REQ-017 wb_busy  out  1  writeback in progress.
REQ-018 wb_done  out  1  one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE, READ, CAPTURE, SEND and DONE.
REQ-020 IDLE with wb_start=1: latch way/index/tag; next state READ. IDLE with wb_start=0: stay in IDLE.
REQ-021 READ: drive index = latched index; assert block0_re or block1_re per latched way, never both; next state CAPTURE.
REQ-022 CAPTURE: load 128-bit line buffer from data0_rd or data1_rd per latched way; read enables low; next state SEND.
REQ-023 SEND: l2_wr_req=1; l2_wr_addr and l2_wr_data SHALL be held stable from the buffer until ack.
REQ-024 SEND: l2_wr_ack=1 (including ack in the first SEND cycle) moves to DONE; otherwise stay in SEND indefinitely.
REQ-025 DONE: wb_done=1 for exactly one cycle; next state IDLE.
REQ-026 wb_busy SHALL be 1 in READ, CAPTURE and SEND, and 0 in IDLE and DONE.
REQ-027 Minimum latency: wb_start at cycle N gives l2_wr_req at N+3 and wb_done at N+4 when ack arrives at N+3.
REQ-028 wb_start outside IDLE SHALL be ignored, with no queueing and no change to the latched fields.
REQ-029 l2_wr_ack outside SEND SHALL be ignored.
REQ-030 l2_wr_req SHALL be 0 in every state except SEND.
REQ-031 The line buffer SHALL be written only in CAPTURE; RAM output changes in other states SHALL have no effect.
REQ-032 When idle, index SHALL output 0.

Reset
REQ-033 On reset=0, asynchronously: state=IDLE; all outputs 0; latched way/index/tag and line buffer cleared to 0.
REQ-034 Reset mid-operation SHALL abort the writeback: l2_wr_req drops immediately, and no wb_done is generated.
REQ-035 After reset deassertion, the first accepted wb_start SHALL be no earlier than the first rising clk edge.

Structure
REQ-036 State encodings (3-bit), the line width (128), tag width (20) and index width (8) SHALL be defined in the shared cache header alongside the existing WORD0..WORD3 and ENABLE/DISABLE constants.
REQ-037 No sub-module is required; the line buffer and FSM SHALL be inline in dcache_wb.
REQ-038 data_ram read ports SHALL connect directly to index and block0_re/block1_re, muxed with the refill path outside this block.

Verification
REQ-039 wb_start, way=0, index=8'h3C, tag=20'hABCDE; way-0 line 128'h00000004_00000003_00000002_00000001; ack held high -> block0_re high only at N+1; l2_wr_addr=28'hABCDE3C with that data at N+3; wb_done at N+4.
REQ-040 way=1, index=8'hFF; ack delayed 5 cycles -> block1_re only; l2_wr_req held for 6 cycles with address/data unchanged; single wb_done.
REQ-041 Second wb_start during SEND with different index -> ignored; address unchanged; exactly one wb_done; busy low on the following cycle.
REQ-042 reset=0 asserted in SEND -> l2_wr_req=0 in the same cycle without a clock edge; no wb_done; a new wb_start after release completes normally.
REQ-043 Spurious l2_wr_ack while in IDLE and in READ -> no state change and no wb_done.
REQ-044 data0_rd toggled in SEND cycles -> l2_wr_data keeps the value captured in CAPTURE.
